// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encodings, loss counter width
// and a small sizing helper.
package pll_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StPllReset = 3'd0;
  localparam state_t StWaitLock = 3'd1;
  localparam state_t StStable   = 3'd2;
  localparam state_t StRun      = 3'd3;
  localparam state_t StFail     = 3'd4;

  localparam int unsigned LossCntW = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous active-high reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset and lock supervisor on the reference clock. Define PLL_SEQ_LOSS_CNT_EN to build
// the saturating lock-loss counter; otherwise loss_count is tied to zero.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned POR_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 74000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 7,
  localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                locked,
  output logic                pll_rst,
  output logic                sys_rst,
  output logic                pll_ready,
  output logic                fail,
  output logic [RW-1:0]       retry_count,
  output logic [LossCntW-1:0] loss_count
);

  localparam int unsigned CntMax = max3(POR_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] PorLast     = CntW'(POR_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0]   RetryMax    = RW'(MAX_RETRIES);

  logic            locked_s;
  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            pll_rst_q, pll_rst_d;
  logic            sys_rst_q, sys_rst_d;
  logic            pll_ready_q, pll_ready_d;
  logic            fail_q, fail_d;

  sync_2ff u_locked_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (locked),
    .q_o   (locked_s)
  );

  // Lock checks are tested before counter terminals so lock loss always wins.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = cnt_q + CntW'(1);
    unique case (state_q)
      StPllReset: begin
        if (cnt_q == PorLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (locked_s) begin
          state_d = StStable;
        end else if (cnt_q == TimeoutLast) begin
          if (retry_q == RetryMax) begin
            state_d = StFail;
          end else begin
            state_d = StPllReset;
            retry_d = retry_q + RW'(1);
          end
        end
      end
      StStable: begin
        if (!locked_s) begin
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          retry_d = '0;
        end
      end
      StRun: begin
        cnt_d = cnt_q;
        if (!locked_s) state_d = StPllReset;
      end
      StFail: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = StPllReset;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs decode the next state so they switch together with the state register.
  always_comb begin
    pll_rst_d   = (state_d == StPllReset) || (state_d == StFail);
    sys_rst_d   = (state_d != StRun);
    pll_ready_d = (state_d == StRun);
    fail_d      = (state_d == StFail);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= StPllReset;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      pll_ready_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      pll_ready_q <= pll_ready_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign pll_ready   = pll_ready_q;
  assign fail        = fail_q;
  assign retry_count = retry_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [LossCntW-1:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if ((state_q == StRun) && !locked_s && (loss_q != '1)) loss_d = loss_q + LossCntW'(1);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign loss_count = loss_q;
`else
  assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst    = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       pll_ready;
  logic       fail;
  logic [1:0] retry_count;
  logic [7:0] loss_count;

  int n_checks = 0;
  int n_bad    = 0;

`ifdef PLL_SEQ_LOSS_CNT_EN
  localparam int unsigned LossAfterOne = 1;
`else
  localparam int unsigned LossAfterOne = 0;
`endif

  pll_reset_sequencer #(
    .POR_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .locked      (locked),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .pll_ready   (pll_ready),
    .fail        (fail),
    .retry_count (retry_count),
    .loss_count  (loss_count)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  // Leaves the bench 1 time unit after edge R, the last edge that sampled rst=1.
  task automatic do_reset();
    rst    = 1'b1;
    locked = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, pll_rst, 1);
    chk({tag, "_sys_rst"}, sys_rst, 1);
    chk({tag, "_ready"}, pll_ready, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_retry"}, retry_count, 0);
    chk({tag, "_loss"}, loss_count, 0);
  endtask

  initial begin
    // Reset state and first bring-up with lock 5 cycles after pll_rst release.
    do_reset();
    chk_reset_vals("rst0");
    tick(3);
    chk("por_hi_r3", pll_rst, 1);
    tick(1);
    chk("por_lo_r4", pll_rst, 0);
    tick(5);
    locked = 1'b1;
    tick(10);
    chk("lock_sys_rst_r19", sys_rst, 1);
    chk("lock_ready_r19", pll_ready, 0);
    tick(1);
    chk("lock_sys_rst_r20", sys_rst, 0);
    chk("lock_ready_r20", pll_ready, 1);
    chk("lock_retry_r20", retry_count, 0);
    chk("lock_pll_rst_r20", pll_rst, 0);

    // Lock loss in RUN.
    locked = 1'b0;
    tick(2);
    chk("loss_sys_rst_2", sys_rst, 0);
    chk("loss_ready_2", pll_ready, 1);
    tick(1);
    chk("loss_sys_rst_3", sys_rst, 1);
    chk("loss_ready_3", pll_ready, 0);
    chk("loss_pll_rst_3", pll_rst, 1);
    chk("loss_count_3", loss_count, LossAfterOne);
    tick(3);
    chk("loss_por_hi", pll_rst, 1);
    tick(1);
    chk("loss_por_lo", pll_rst, 0);

    // Re-lock into RUN, then rst from RUN.
    locked = 1'b1;
    tick(11);
    chk("relock_ready", pll_ready, 1);
    chk("relock_loss", loss_count, LossAfterOne);
    rst = 1'b1;
    tick(1);
    chk_reset_vals("rst_run");
    rst = 1'b0;
    tick(3);
    chk("rst_run_por_hi", pll_rst, 1);
    tick(1);
    chk("rst_run_por_lo", pll_rst, 0);

    // Lock never arrives: two retries then FAIL.
    do_reset();
    tick(23);
    chk("to_pll_rst_r23", pll_rst, 0);
    chk("to_retry_r23", retry_count, 0);
    tick(1);
    chk("to_pll_rst_r24", pll_rst, 1);
    chk("to_retry_r24", retry_count, 1);
    tick(3);
    chk("to_pll_rst_r27", pll_rst, 1);
    tick(1);
    chk("to_pll_rst_r28", pll_rst, 0);
    tick(19);
    chk("to_pll_rst_r47", pll_rst, 0);
    chk("to_retry_r47", retry_count, 1);
    tick(1);
    chk("to_pll_rst_r48", pll_rst, 1);
    chk("to_retry_r48", retry_count, 2);
    tick(23);
    chk("to_fail_r71", fail, 0);
    chk("to_pll_rst_r71", pll_rst, 0);
    tick(1);
    chk("to_fail_r72", fail, 1);
    chk("to_pll_rst_r72", pll_rst, 1);
    chk("to_sys_rst_r72", sys_rst, 1);
    chk("to_retry_r72", retry_count, 2);
    tick(50);
    chk("fail_hold", fail, 1);
    chk("fail_hold_pll_rst", pll_rst, 1);
    chk("fail_hold_sys_rst", sys_rst, 1);
    chk("fail_hold_ready", pll_ready, 0);

    // rst from FAIL.
    rst = 1'b1;
    tick(1);
    chk_reset_vals("rst_fail");
    rst = 1'b0;
    tick(3);
    chk("rst_fail_por_hi", pll_rst, 1);
    tick(1);
    chk("rst_fail_por_lo", pll_rst, 0);

    // One timeout, then a 2-cycle lock drop in STABLE at cnt=5.
    do_reset();
    tick(24);
    chk("gl_retry_b0", retry_count, 1);
    chk("gl_pll_rst_r24", pll_rst, 1);
    tick(4);
    chk("gl_pll_rst_b", pll_rst, 0);
    locked = 1'b1;
    tick(6);
    locked = 1'b0;
    tick(2);
    locked = 1'b1;
    tick(1);
    chk("gl_sys_rst_b9", sys_rst, 1);
    chk("gl_retry_b9", retry_count, 1);
    tick(2);
    chk("gl_sys_rst_b11", sys_rst, 1);
    tick(7);
    chk("gl_sys_rst_b18", sys_rst, 1);
    chk("gl_retry_b18", retry_count, 1);
    tick(1);
    chk("gl_sys_rst_b19", sys_rst, 0);
    chk("gl_ready_b19", pll_ready, 1);
    chk("gl_retry_b19", retry_count, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset and lock supervisor for the 74 MHz → 50 MHz system PLL. Runs on the PLL reference clock, drives the PLL `rst` input, watches the asynchronous `locked` output, and produces a single system reset that stays asserted until lock has been stable for a programmable time. It retries PLL bring-up on lock timeout, recovers from lock loss, and flags permanent failure. Downstream 50 MHz logic re-synchronises `sys_rst` into its own domain.

## Interface
- `POR_CYCLES`, 16: width of each `pll_rst` pulse, in refclk cycles (≥1).
- `LOCK_TIMEOUT`, 74000: cycles to wait for lock after `pll_rst` release (1 ms at 74 MHz).
- `STABLE_CYCLES`, 1024: cycles lock must hold continuously before `sys_rst` releases.
- `MAX_RETRIES`, 7: PLL reset retries after the first attempt before declaring failure.
- `refclk`  in  1  74 MHz reference clock; the block's only clock.
- `rst`  in  1  synchronous, active-high reset.
- `locked`  in  1  PLL lock, asynchronous to `refclk`.
- `pll_rst`  out  1  reset to PLL, active-high.
- `sys_rst`  out  1  system reset, active-high.
- `pll_ready`  out  1  high only in RUN.
- `fail`  out  1  sticky failure flag.
- `retry_count`  out  RW  retries used in the current bring-up; RW = $clog2(MAX_RETRIES+1).
- `loss_count`  out  8  lock-loss event count (see Configuration).

## Operation
- `locked` passes through a 2-flop synchroniser → `locked_s`; only `locked_s` is used.
- One counter `cnt`, width $clog2(max(POR_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)); cleared on every state change.
- States and transitions:
  - PLL_RESET: `pll_rst`=1. When `cnt`==POR_CYCLES-1 → WAIT_LOCK.
  - WAIT_LOCK: `pll_rst`=0. If `locked_s` → STABLE. Else, when `cnt`==LOCK_TIMEOUT-1: if `retry_count`==MAX_RETRIES → FAIL; otherwise increment `retry_count` and go to PLL_RESET.
  - STABLE: if `!locked_s` → WAIT_LOCK; the timeout restarts and `retry_count` is unchanged. Else, when `cnt`==STABLE_CYCLES-1 → RUN and clear `retry_count`.
  - RUN: `sys_rst`=0, `pll_ready`=1. If `!locked_s` → PLL_RESET (a lock-loss event).
  - FAIL: `pll_rst`=1, `sys_rst`=1, `fail`=1. Terminal until `rst`.
- `sys_rst`=1 in every state except RUN.
- A lock-loss check in the same cycle as a counter terminal value takes priority over the counter transition.

## Timing
- Reset values: state PLL_RESET, `cnt`=0, `pll_rst`=1, `sys_rst`=1, `pll_ready`=0, `fail`=0, `retry_count`=0, `loss_count`=0, synchroniser flops=0.
- Outputs are registered and decoded from the next state, so each output changes in the same cycle the state register enters the new state.
- `pll_rst` stays high for exactly POR_CYCLES cycles per pulse.
- `locked` rising to WAIT_LOCK→STABLE: 3 edges (2 synchroniser edges + 1 state edge).
- STABLE→RUN: exactly STABLE_CYCLES cycles with `locked_s` high.
- Lock loss in RUN: `sys_rst`=1 and `pll_ready`=0 three edges after `locked` falls.
- `rst` mid-operation returns the block to reset values on the next edge, from any state including FAIL.
- A `locked` glitch shorter than 1 cycle may be missed; this is accepted, since STABLE filters lock.

## Configuration
- `PLL_SEQ_LOSS_CNT_EN` defined: `loss_count` increments on each RUN→PLL_RESET transition, saturates at 255, and clears only on `rst`.
- Not defined: `loss_count` is tied to 0 and no counter logic is built. The port always exists.

## Structure
- Package `pll_seq_pkg`: state enum (PLL_RESET, WAIT_LOCK, STABLE, RUN, FAIL) and the `loss_count` width constant.
- Sub-module `sync_2ff` (1-bit two-flop synchroniser, reset to 0) for `locked`.

## Test plan
Use POR_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- Lock 5 cycles after `pll_rst` falls, held → `pll_rst` high 4 cycles; `sys_rst` falls after 3+8 edges from `locked`; `pll_ready`=1; `retry_count`=0.
- `locked` never asserts → 3 `pll_rst` pulses spaced 4+20 cycles apart; `retry_count` 0→1→2; then `fail`=1, `pll_rst`=1, `sys_rst`=1 permanently.
- `locked` drops for 2 cycles in STABLE at `cnt`=5 → returns to WAIT_LOCK, `retry_count` unchanged; after re-lock, a full 8-cycle STABLE before `sys_rst`=0.
- `locked` drops in RUN → `sys_rst`=1 three edges later; 4-cycle `pll_rst` pulse; `loss_count`=1 with macro, 0 without.
- `rst` asserted in FAIL and in RUN → all outputs at reset values next edge; sequence restarts at PLL_RESET.
